// File: rtl/spi_gen_pkg.sv
// Shared definitions for the SPI slave front end.
//   state_e     : FSM state encoding
//   CMD_*       : 2-bit command codes carried in the top bits of each frame
package spi_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_TX_WAIT,
      ST_TX,
      ST_DONE
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register used for both directions of the SPI slave.
//   clk, rst   : clock, synchronous active-high reset (clears contents)
//   load       : parallel load of load_data (has priority over shift_en)
//   shift_en   : shift left by one, shift_in enters at bit 0
//   q_shift    : value the register would hold after a shift this cycle
//   ser_out    : current MSB (serial output)
module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift_en,
   input  logic         shift_in,
   output logic [W-1:0] q_shift,
   output logic         ser_out
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = load_data;
      end else if (shift_en) begin
         data_d = {data_q[W-2:0], shift_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_shift = {data_q[W-2:0], shift_in};
   assign ser_out = data_q[W-1];

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front end for the single-port RAM subsystem.
//   clk, rst          : system/bit clock, synchronous active-high reset
//   SS_n, MOSI        : slave select (active low), serial data in (MSB first)
//   MISO              : serial read data out (MSB first), 0 outside TX
//   rx_data, rx_valid : last complete frame (command in MSBs), 1-cycle strobe
//   tx_valid, tx_data : read data handshake from the RAM controller
//   err               : 1-cycle pulse on read without address or tx timeout
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for SS_n low
// RX      | shifting in a CMD_W+DATA_W frame
// TX_WAIT | read-data frame received, waiting for tx_valid (timed)
// TX      | shifting out DATA_W bits of read data on MISO
// DONE    | frame finished, waiting for SS_n high
module spi_slave_gen
   import spi_gen_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CMD_W      = 2,
   parameter int BURST_EN   = 0,
   parameter int TX_TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    SS_n,
   input  logic                    MOSI,
   output logic                    MISO,
   output logic [CMD_W+DATA_W-1:0] rx_data,
   output logic                    rx_valid,
   input  logic                    tx_valid,
   input  logic [DATA_W-1:0]       tx_data,
   output logic                    err
);

   localparam int FRAME_W  = CMD_W + DATA_W;
   localparam int RX_CNT_W = $clog2(FRAME_W);
   localparam int TX_CNT_W = $clog2(DATA_W);
   localparam int TMO_W    = $clog2(TX_TIMEOUT + 1);

   localparam logic [RX_CNT_W-1:0] RX_LAST  = RX_CNT_W'(FRAME_W - 1);
   localparam logic [TX_CNT_W-1:0] TX_LAST  = TX_CNT_W'(DATA_W - 1);
   // Terminal count is reached on the TX_TIMEOUT-th cycle spent in TX_WAIT.
   localparam logic [TMO_W-1:0]    TMO_LOAD = TMO_W'(TX_TIMEOUT - 1);
   localparam state_e              ST_AFTER = (BURST_EN != 0) ? ST_RX : ST_DONE;

   state_e              state_q, state_d;
   logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                rd_addr_ok_q, rd_addr_ok_d;
   logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                err_q, err_d;

   logic                rx_shift;
   logic                tx_load;
   logic                tx_shift;
   logic [DATA_W-1:0]   tx_ld_val;
   logic [FRAME_W-1:0]  rx_frame;
   logic [1:0]          rx_cmd;
   logic                rx_ser_unused;
   logic [DATA_W-1:0]   tx_shift_unused;

   spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ('0),
      .shift_en  (rx_shift),
      .shift_in  (MOSI),
      .q_shift   (rx_frame),
      .ser_out   (rx_ser_unused)
   );

   // MISO comes straight from the TX register MSB. The register is zero
   // outside TX: it is cleared on reset, empties itself after DATA_W shifts
   // of zeros, and is loaded with zero on abort.
   spi_shift_reg #(.W(DATA_W)) u_tx_sr (
      .clk       (clk),
      .rst       (rst),
      .load      (tx_load),
      .load_data (tx_ld_val),
      .shift_en  (tx_shift),
      .shift_in  (1'b0),
      .q_shift   (tx_shift_unused),
      .ser_out   (MISO)
   );

   assign rx_cmd = rx_frame[FRAME_W-1 -: 2];

   always_comb begin
      state_d      = state_q;
      rx_cnt_d     = rx_cnt_q;
      tx_cnt_d     = tx_cnt_q;
      tmo_d        = tmo_q;
      rd_addr_ok_d = rd_addr_ok_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      err_d        = 1'b0;
      rx_shift     = 1'b0;
      tx_load      = 1'b0;
      tx_ld_val    = '0;
      tx_shift     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            tx_cnt_d = '0;
            if (!SS_n) begin
               state_d = ST_RX;
            end
         end

         ST_RX: begin
            if (SS_n) begin
               state_d  = ST_IDLE;
               rx_cnt_d = '0;
            end else begin
               rx_shift = 1'b1;
               if (rx_cnt_q == RX_LAST) begin
                  rx_cnt_d   = '0;
                  rx_data_d  = rx_frame;
                  rx_valid_d = 1'b1;
                  if (rx_cmd == CMD_RD_DATA) begin
                     err_d   = !rd_addr_ok_q;
                     tmo_d   = TMO_LOAD;
                     state_d = ST_TX_WAIT;
                  end else begin
                     if (rx_cmd == CMD_RD_ADDR) begin
                        rd_addr_ok_d = 1'b1;
                     end
                     state_d = ST_AFTER;
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + RX_CNT_W'(1);
               end
            end
         end

         ST_TX_WAIT: begin
            if (SS_n) begin
               state_d = ST_IDLE;
            end else if (tx_valid) begin
               tx_load   = 1'b1;
               tx_ld_val = tx_data;
               tx_cnt_d  = '0;
               state_d   = ST_TX;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end

         ST_TX: begin
            if (SS_n) begin
               state_d  = ST_IDLE;
               tx_cnt_d = '0;
               tx_load  = 1'b1;
            end else begin
               tx_shift = 1'b1;
               if (tx_cnt_q == TX_LAST) begin
                  tx_cnt_d     = '0;
                  rd_addr_ok_d = 1'b0;
                  state_d      = ST_AFTER;
               end else begin
                  tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
               end
            end
         end

         ST_DONE: begin
            if (SS_n) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rx_cnt_q     <= '0;
         tx_cnt_q     <= '0;
         tmo_q        <= '0;
         rd_addr_ok_q <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_cnt_q     <= rx_cnt_d;
         tx_cnt_q     <= tx_cnt_d;
         tmo_q        <= tmo_d;
         rd_addr_ok_q <= rd_addr_ok_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         err_q        <= err_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign err      = err_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: instance A (BURST_EN=0) covers write,
// read, read-without-address, timeout and abort; instance B (BURST_EN=1)
// covers back-to-back frames and mid-frame reset.
module tb_spi_slave_gen;

   logic       clk = 1'b0;
   logic       rst;

   logic       ss_a, mosi_a, miso_a, rxv_a, tx_valid_a, err_a;
   logic [9:0] rx_data_a;
   logic [7:0] tx_data_a;

   logic       ss_b, mosi_b, miso_b, rxv_b, tx_valid_b, err_b;
   logic [9:0] rx_data_b;
   logic [7:0] tx_data_b;

   int         n_checks = 0;
   int         n_errors = 0;

   logic        flag;
   logic [7:0]  rd_byte;
   logic [19:0] bb;
   logic [9:0]  fr;
   int          np, p0, p1;
   logic [9:0]  d0, d1;

   always #5 clk = ~clk;

   spi_slave_gen #(.DATA_W(8), .CMD_W(2), .BURST_EN(0), .TX_TIMEOUT(15)) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .SS_n     (ss_a),
      .MOSI     (mosi_a),
      .MISO     (miso_a),
      .rx_data  (rx_data_a),
      .rx_valid (rxv_a),
      .tx_valid (tx_valid_a),
      .tx_data  (tx_data_a),
      .err      (err_a)
   );

   spi_slave_gen #(.DATA_W(8), .CMD_W(2), .BURST_EN(1), .TX_TIMEOUT(15)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .SS_n     (ss_b),
      .MOSI     (mosi_b),
      .MISO     (miso_b),
      .rx_data  (rx_data_b),
      .rx_valid (rxv_b),
      .tx_valid (tx_valid_b),
      .tx_data  (tx_data_b),
      .err      (err_b)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Starts from IDLE, drives one frame on A and checks the result strobe.
   task automatic send_a(input logic [9:0] f, input logic exp_err, input string tag);
      logic early;
      logic miso_seen;
      early     = 1'b0;
      miso_seen = 1'b0;
      ss_a = 1'b0;
      cyc();
      for (int i = 9; i >= 0; i--) begin
         mosi_a = f[i];
         if (rxv_a || err_a) early = 1'b1;
         if (miso_a) miso_seen = 1'b1;
         cyc();
      end
      chk_val({tag, "_early"}, 32'(early), 32'd0);
      chk_val({tag, "_rxv"}, 32'(rxv_a), 32'd1);
      chk_val({tag, "_data"}, 32'(rx_data_a), 32'(f));
      chk_val({tag, "_err"}, 32'(err_a), 32'(exp_err));
      chk_val({tag, "_miso"}, 32'(miso_seen | miso_a), 32'd0);
   endtask

   // Called right after the edge that accepted tx_valid.
   task automatic read_byte_a(output logic [7:0] b);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         b = {b[6:0], miso_a};
         cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ss_a = 1'b1; mosi_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = 8'h00;
      ss_b = 1'b1; mosi_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = 8'h00;
      cyc();
      cyc();
      chk_val("rst_miso", 32'(miso_a), 32'd0);
      chk_val("rst_rxdata", 32'(rx_data_a), 32'd0);
      chk_val("rst_rxv", 32'(rxv_a), 32'd0);
      chk_val("rst_err", 32'(err_a), 32'd0);
      rst = 1'b0;
      cyc();

      // writes, SS_n high between frames
      send_a(10'h012, 1'b0, "wr1");
      cyc();
      chk_val("wr1_pulse_end", 32'(rxv_a), 32'd0);
      ss_a = 1'b1; cyc();
      send_a(10'h1AA, 1'b0, "wr2");
      cyc();
      chk_val("wr2_pulse_end", 32'(rxv_a), 32'd0);
      ss_a = 1'b1; cyc();

      // read address then read data, tx_valid 3 cycles after rx_valid
      send_a(10'h205, 1'b0, "rda");
      ss_a = 1'b1; cyc();
      send_a(10'h300, 1'b0, "rdd");
      flag = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (err_a || miso_a) flag = 1'b1;
      end
      tx_valid_a = 1'b1; tx_data_a = 8'hA5;
      cyc();
      tx_valid_a = 1'b0; tx_data_a = 8'h00;
      read_byte_a(rd_byte);
      chk_val("rd_miso_bits", 32'(rd_byte), 32'hA5);
      chk_val("rd_miso_end", 32'(miso_a), 32'd0);
      chk_val("rd_wait_quiet", 32'(flag), 32'd0);
      ss_a = 1'b1; cyc();

      // address flag consumed: read data again flags err, then times out
      send_a(10'h300, 1'b1, "rdd_cleared");
      flag = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         if (k < 15 && err_a) flag = 1'b1;
         if (miso_a) flag = 1'b1;
      end
      chk_val("tmo_err", 32'(err_a), 32'd1);
      chk_val("tmo_early", 32'(flag), 32'd0);
      cyc();
      chk_val("tmo_err_pulse", 32'(err_a), 32'd0);
      // DONE ignores MOSI while SS_n stays low
      flag = 1'b0;
      for (int k = 0; k < 12; k++) begin
         mosi_a = k[0];
         cyc();
         if (rxv_a || err_a || miso_a) flag = 1'b1;
      end
      chk_val("done_ignores", 32'(flag), 32'd0);
      ss_a = 1'b1; cyc();

      // tx_valid on the timeout edge wins; aborted TX keeps the address flag
      send_a(10'h205, 1'b0, "rda2");
      ss_a = 1'b1; cyc();
      send_a(10'h300, 1'b0, "rdd2");
      for (int k = 1; k <= 14; k++) cyc();
      tx_valid_a = 1'b1; tx_data_a = 8'h81;
      cyc();
      tx_valid_a = 1'b0;
      chk_val("tie_err", 32'(err_a), 32'd0);
      chk_val("tie_miso", 32'(miso_a), 32'd1);
      cyc();
      cyc();
      ss_a = 1'b1;
      cyc();
      chk_val("abort_tx_miso", 32'(miso_a), 32'd0);
      send_a(10'h300, 1'b0, "rdd_after_abort");
      ss_a = 1'b1; cyc();

      // read data without address after reset; TX still runs
      rst = 1'b1; cyc(); rst = 1'b0;
      chk_val("rst2_rxdata", 32'(rx_data_a), 32'd0);
      send_a(10'h3AB, 1'b1, "noaddr");
      cyc();
      chk_val("noaddr_err_pulse", 32'(err_a), 32'd0);
      cyc();
      tx_valid_a = 1'b1; tx_data_a = 8'h3C;
      cyc();
      tx_valid_a = 1'b0;
      read_byte_a(rd_byte);
      chk_val("noaddr_miso_bits", 32'(rd_byte), 32'h3C);
      chk_val("noaddr_miso_end", 32'(miso_a), 32'd0);
      ss_a = 1'b1; cyc();

      // abort after 6 bits, then full frame 0x3FF
      flag = 1'b0;
      ss_a = 1'b0; cyc();
      for (int k = 0; k < 6; k++) begin
         mosi_a = 1'b1;
         cyc();
         if (rxv_a) flag = 1'b1;
      end
      ss_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (rxv_a) flag = 1'b1;
      end
      chk_val("abort_no_rxv", 32'(flag), 32'd0);
      send_a(10'h3FF, 1'b1, "after_abort");
      ss_a = 1'b1; cyc();
      chk_val("abort_wait_miso", 32'(miso_a), 32'd0);

      // SS_n high on the edge that samples the last bit: frame dropped
      fr = 10'h012;
      ss_a = 1'b0; cyc();
      for (int i = 9; i >= 1; i--) begin
         mosi_a = fr[i];
         cyc();
      end
      mosi_a = fr[0];
      ss_a = 1'b1;
      cyc();
      chk_val("lastbit_abort_rxv", 32'(rxv_a), 32'd0);
      chk_val("lastbit_abort_data", 32'(rx_data_a), 32'h3FF);
      cyc();

      // burst: two frames back-to-back on B
      bb = {10'h012, 10'h1AA};
      np = 0; p0 = -1; p1 = -1; d0 = '0; d1 = '0;
      ss_b = 1'b0; cyc();
      for (int i = 0; i < 20; i++) begin
         mosi_b = bb[19-i];
         cyc();
         if (rxv_b) begin
            if (np == 0) begin p0 = i; d0 = rx_data_b; end
            else begin p1 = i; d1 = rx_data_b; end
            np++;
         end
      end
      chk_val("burst_npulse", 32'(np), 32'd2);
      chk_val("burst_first_at", 32'(p0), 32'd9);
      chk_val("burst_spacing", 32'(p1 - p0), 32'd10);
      chk_val("burst_data0", 32'(d0), 32'h012);
      chk_val("burst_data1", 32'(d1), 32'h1AA);
      chk_val("burst_err", 32'(err_b), 32'd0);

      // reset mid-frame
      for (int k = 0; k < 4; k++) begin
         mosi_b = 1'b1;
         cyc();
      end
      rst = 1'b1;
      cyc();
      chk_val("midrst_rxdata", 32'(rx_data_b), 32'd0);
      chk_val("midrst_rxv", 32'(rxv_b), 32'd0);
      chk_val("midrst_err", 32'(err_b), 32'd0);
      chk_val("midrst_miso", 32'(miso_b), 32'd0);
      rst = 1'b0;
      fr = 10'h155;
      cyc();
      for (int i = 9; i >= 0; i--) begin
         mosi_b = fr[i];
         cyc();
      end
      chk_val("postrst_rxv", 32'(rxv_b), 32'd1);
      chk_val("postrst_data", 32'(rx_data_b), 32'h155);
      ss_b = 1'b1;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
